seq_responder: RTL and testbench
================================

# seq_responder

Responder end of the single-bit request/acknowledge sequence protocol used throughout the SVA lab material. It samples a request `a`, answers with a one-cycle acknowledge `b` a fixed number of clocks later, then holds an unconditional tail window before signalling sequence completion. It is the device-under-test counterpart to the request-driving stimulus and checker benches. It also keeps saturating statistics of completed sequences and dropped requests.

## Interface
- `ACK_DLY`, 1, clocks from request sample to acknowledge sample; legal range 1..15.
- `TAIL`, 2, unconditional extension in clocks after the acknowledge, before completion; legal range 1..15.
- `CNT_W`, 8, width of the statistics counters.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1 — rising-edge clock.
- `rst` input 1 — asynchronous, active-high reset.
- `a` input 1 — request, sampled on the rising edge of `clk`.
- `ready` output 1 — request will be accepted if `a` is high at this edge.
- `b` output 1 — acknowledge, high for exactly one cycle.
- `busy` output 1 — a sequence is in progress.
- `match` output 1 — one-cycle completion pulse.
- `ovr` output 1 — one-cycle pulse when a request was dropped.
- `match_cnt` output `CNT_W` — completed sequences, saturating.
- `ovr_cnt` output `CNT_W` — dropped requests, saturating.

## Operation
- **States:** IDLE, DLY, ACK, TAIL. There is a 4-bit down-counter `cnt`.
- **IDLE:** on `a`=1 go to ACK if `ACK_DLY`==1; otherwise go to DLY with `cnt`=`ACK_DLY`-2.
- **DLY:** decrement `cnt`; when `cnt`==0, go to ACK.
- **ACK:** go to TAIL with `cnt`=`TAIL`-1.
- **TAIL:** decrement `cnt`. When `cnt`==0:
  - if `a`=1, accept it as a new request (same transition as from IDLE);
  - otherwise go to IDLE.
- **Output decodes** (all from registered state):
  - `b` = (state==ACK)
  - `busy` = (state!=IDLE)
  - `ready` = IDLE, or (TAIL and `cnt`==0)
  - `match` = (TAIL and `cnt`==0)
- **Dropped request:** `a`=1 while `ready`=0 is dropped. `ovr` is registered high the next cycle and `ovr_cnt` increments.
- **Completion count:** `match_cnt` increments at every edge where `match`=1.
- **Counters:** both stick at 2^`CNT_W`-1 and never wrap.
- **Back-to-back:** a request accepted in the final tail cycle both completes the old sequence (`match`) and starts the new one. This request is not an overrun.
- **Reset:** asserting `rst` mid-sequence forces IDLE with no `match` pulse. All outputs return to their reset values immediately.

## Timing
- **Reset values:** state IDLE, `cnt` 0, `b` 0, `busy` 0, `ready` 1, `match` 0, `ovr` 0, `match_cnt` 0, `ovr_cnt` 0.
- **Latency:** request accepted at edge N gives:
  - `b` sampled high at edge N+`ACK_DLY`;
  - `match` sampled high at edge N+`ACK_DLY`+`TAIL`.
- **Defaults:** request at N gives `b` at N+1 and `match` at N+3.
- **Throughput:** the minimum request spacing is `ACK_DLY`+`TAIL` clocks.
- `ovr` lags the dropped request by one edge.
- There is no combinational path from `a` to any output.

## Configuration
- **`SEQ_RESP_SVA_EN` defined:** compiles in concurrent assertions clocked on `posedge clk` and disabled iff `rst`:
  - `a && ready |-> ##ACK_DLY b ##TAIL match`
  - `b |=> !b`
  - `match |-> busy`
  - `$onehot0({b, match})`
  
  It also compiles in a cover property on the back-to-back case.
- **Undefined:** no assertion or cover code is present, and RTL behaviour is identical.

## Structure
- **`seq_resp_pkg`:** holds the `state_t` enum (IDLE, DLY, ACK, TAIL) and the localparam bound 15 for `ACK_DLY`/`TAIL`. It also holds an elaboration-time range check that issues `$fatal` on illegal parameters.
- **`seq_resp_satcnt`:** one sub-module, a parameterised saturating counter (`clk`, `rst`, `inc`, `q`). It is instantiated twice, for `match_cnt` and `ovr_cnt`.

## Test plan
- **Single request, defaults:** `a` pulsed at edge 1 → `b`=1 at edge 2, `match`=1 at edge 4, `match_cnt`=1, `busy` high at edges 2–4.
- **Overrun:** `a` high at edges 1 and 2 → second request dropped, `ovr`=1 at edge 3, `ovr_cnt`=1, only one `b`.
- **Back-to-back:** `a` at edge 1 and edge 4 → `match` at 4, second `b` at 5, second `match` at 7, `ovr_cnt`=0.
- **Non-default timing:** `ACK_DLY`=3, `TAIL`=1, `a` at edge 1 → `b` at edge 4, `match` at edge 5.
- **Reset mid-sequence:** `rst` asserted asynchronously between edges 2 and 3 → `busy`/`b`/`match` drop at once, `match_cnt` stays 0, next `a` accepted normally.
- **Saturation:** `CNT_W`=2, five sequences → `match_cnt` holds 3.

Source files
------------

// File: rtl/seq_resp_pkg.sv
// Shared types and parameter checks for the sequence responder.
package seq_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DLY  = 2'd1,
        ST_ACK  = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    localparam int SEQ_MAX_DLY = 15;

    function automatic bit seq_resp_params_ok(input int ack_dly, input int tail, input int cnt_w);
        return (ack_dly >= 1) && (ack_dly <= SEQ_MAX_DLY) &&
               (tail >= 1) && (tail <= SEQ_MAX_DLY) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/seq_responder_if.sv
// Request/acknowledge bus between the request driver (master) and the responder (slave).
interface seq_responder_if #(parameter int CNT_W = 8) ();

    logic             a;
    logic             ready;
    logic             b;
    logic             busy;
    logic             match;
    logic             ovr;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] ovr_cnt;

    modport master (
        output a,
        input  ready, b, busy, match, ovr, match_cnt, ovr_cnt
    );

    modport slave (
        input  a,
        output ready, b, busy, match, ovr, match_cnt, ovr_cnt
    );

endinterface

// File: rtl/seq_resp_satcnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module seq_resp_satcnt
    import seq_resp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_responder.sv
// Sequence responder: acknowledges a request after ACK_DLY clocks, completes TAIL clocks later.
// Optional assertions/cover are compiled in with SEQ_RESP_SVA_EN.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for a request, ready
//   DLY     | counting down to the acknowledge
//   ACK     | b high for this one cycle
//   TAIL    | post-ack window; cnt==0 is completion + ready
module seq_responder
    import seq_resp_pkg::*;
#(
    parameter int ACK_DLY = 1,
    parameter int TAIL    = 2,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    seq_responder_if.slave  bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_DLY  = ST_DLY;
    localparam logic [1:0] S_ACK  = ST_ACK;
    localparam logic [1:0] S_TAIL = ST_TAIL;

    localparam logic [3:0] DLY_LOAD  = 4'(ACK_DLY - 2);
    localparam logic [3:0] TAIL_LOAD = 4'(TAIL - 1);

    if (!seq_resp_params_ok(ACK_DLY, TAIL, CNT_W)) begin : g_bad_params
        $fatal(1, "seq_responder: ACK_DLY/TAIL must be 1..15 and CNT_W >= 1");
    end

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       ovr_q;
    logic       tail_done;
    logic       ready_w;
    logic       accept;
    logic       drop;
    logic       b_w;
    logic       match_w;

    assign tail_done = (state_q == S_TAIL) && (cnt_q == 4'd0);
    assign ready_w   = (state_q == S_IDLE) || tail_done;
    assign accept    = bus.a && ready_w;
    assign drop      = bus.a && !ready_w;
    assign b_w       = (state_q == S_ACK);
    assign match_w   = tail_done;

    // A request accepted in the last tail cycle restarts the sequence directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (ACK_DLY == 1) begin
                state_d = S_ACK;
            end else begin
                state_d = S_DLY;
                cnt_d   = DLY_LOAD;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_DLY: begin
                    if (cnt_q == 4'd0) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    state_d = S_TAIL;
                    cnt_d   = TAIL_LOAD;
                end
                S_TAIL: begin
                    if (cnt_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= drop;
        end
    end

    assign bus.ready = ready_w;
    assign bus.b     = b_w;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.match = match_w;
    assign bus.ovr   = ovr_q;

    seq_resp_satcnt #(.W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match_w),
        .q   (bus.match_cnt)
    );

    seq_resp_satcnt #(.W(CNT_W)) u_ovr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop),
        .q   (bus.ovr_cnt)
    );

`ifdef SEQ_RESP_SVA_EN
    a_seq_timing: assert property (@(posedge clk) disable iff (rst)
        bus.a && ready_w |-> ##ACK_DLY b_w ##TAIL match_w);
    a_b_single: assert property (@(posedge clk) disable iff (rst) b_w |=> !b_w);
    a_match_busy: assert property (@(posedge clk) disable iff (rst) match_w |-> (state_q != S_IDLE));
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0({b_w, match_w}));
    c_back_to_back: cover property (@(posedge clk) disable iff (rst) match_w && bus.a);
`endif

endmodule

// File: tb/tb_seq_responder.sv
// Scoreboard bench for seq_responder: default, slow-timing and narrow-counter instances.
module tb_seq_responder;

    logic clk;
    logic rst;
    int   edge_n;
    int   checks;
    int   errors;

    int exp_d[$];
    int obs_d[$];
    int exp_s[$];
    int obs_s[$];

    seq_responder_if #(.CNT_W(8)) if_d ();
    seq_responder_if #(.CNT_W(8)) if_s ();
    seq_responder_if #(.CNT_W(2)) if_t ();

    seq_responder #(.ACK_DLY(1), .TAIL(2), .CNT_W(8)) dut_d (.clk(clk), .rst(rst), .bus(if_d));
    seq_responder #(.ACK_DLY(3), .TAIL(1), .CNT_W(8)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
    seq_responder #(.ACK_DLY(1), .TAIL(2), .CNT_W(2)) dut_t (.clk(clk), .rst(rst), .bus(if_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Event code = edge*4 + kind (1 = b, 2 = match, 3 = ovr), edge = the edge that samples it.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_d.b)     obs_d.push_back((edge_n + 1) * 4 + 1);
            if (if_d.match) obs_d.push_back((edge_n + 1) * 4 + 2);
            if (if_d.ovr)   obs_d.push_back((edge_n + 1) * 4 + 3);
            if (if_s.b)     obs_s.push_back((edge_n + 1) * 4 + 1);
            if (if_s.match) obs_s.push_back((edge_n + 1) * 4 + 2);
            if (if_s.ovr)   obs_s.push_back((edge_n + 1) * 4 + 3);
        end
    end

    task automatic do_reset();
        if_d.a = 1'b0;
        if_s.a = 1'b0;
        if_t.a = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_d.delete();
        obs_d.delete();
        exp_s.delete();
        obs_s.delete();
    endtask

    // Bit i of pat is the request seen at edge t0+1+i; busy_v[i] is busy sampled at that edge.
    task automatic drive(input int which, input logic [31:0] pat, input int ncyc,
                         output logic [31:0] busy_v);
        busy_v = '0;
        for (int i = 0; i < ncyc; i++) begin
            case (which)
                0:       if_d.a = pat[i];
                1:       if_s.a = pat[i];
                default: if_t.a = pat[i];
            endcase
            case (which)
                0:       busy_v[i] = if_d.busy;
                1:       busy_v[i] = if_s.busy;
                default: busy_v[i] = if_t.busy;
            endcase
            @(negedge clk);
        end
        if_d.a = 1'b0;
        if_s.a = 1'b0;
        if_t.a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_d.a = 1'b0;
        if_s.a = 1'b0;
        if_t.a = 1'b0;
        @(negedge clk);
        checks++; if (if_d.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", if_d.ready); end
        checks++; if (if_d.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if_d.busy); end
        checks++; if (if_d.b !== 1'b0) begin errors++; $display("FAIL reset_b got %b want 0", if_d.b); end
        checks++; if (if_d.match !== 1'b0) begin errors++; $display("FAIL reset_match got %b want 0", if_d.match); end
        checks++; if (if_d.ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", if_d.ovr); end
        checks++; if (if_d.match_cnt !== 8'd0) begin errors++; $display("FAIL reset_match_cnt got %0d want 0", if_d.match_cnt); end
        checks++; if (if_d.ovr_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovr_cnt got %0d want 0", if_d.ovr_cnt); end
        checks++; if (if_s.ready !== 1'b1) begin errors++; $display("FAIL reset_slow_ready got %b want 1", if_s.ready); end
        checks++; if (if_t.match_cnt !== 2'd0) begin errors++; $display("FAIL reset_sat_cnt got %0d want 0", if_t.match_cnt); end
        do_reset();
    endtask

    task automatic test_single();
        int t0, e, o;
        logic [31:0] bv;
        do_reset();
        t0 = edge_n;
        exp_d.push_back((t0 + 2) * 4 + 1);
        exp_d.push_back((t0 + 4) * 4 + 2);
        drive(0, 32'h1, 7, bv);
        repeat (2) @(negedge clk);
        exp_d.sort();
        while (exp_d.size() > 0) begin
            e = exp_d.pop_front();
            o = (obs_d.size() > 0) ? obs_d.pop_front() : -4;
            checks++;
            if (o !== e) begin errors++; $display("FAIL single_event got edge %0d kind %0d want edge %0d kind %0d", o / 4 - t0, o % 4, e / 4 - t0, e % 4); end
        end
        checks++; if (obs_d.size() != 0) begin errors++; $display("FAIL single_extra got %0d events want 0", obs_d.size()); end
        checks++; if (bv[6:0] !== 7'b0001110) begin errors++; $display("FAIL single_busy got %b want 0001110", bv[6:0]); end
        checks++; if (if_d.match_cnt !== 8'd1) begin errors++; $display("FAIL single_match_cnt got %0d want 1", if_d.match_cnt); end
    endtask

    task automatic test_overrun();
        int t0, e, o;
        logic [31:0] bv;
        do_reset();
        t0 = edge_n;
        exp_d.push_back((t0 + 2) * 4 + 1);
        exp_d.push_back((t0 + 3) * 4 + 3);
        exp_d.push_back((t0 + 4) * 4 + 2);
        drive(0, 32'b11, 7, bv);
        repeat (2) @(negedge clk);
        exp_d.sort();
        while (exp_d.size() > 0) begin
            e = exp_d.pop_front();
            o = (obs_d.size() > 0) ? obs_d.pop_front() : -4;
            checks++;
            if (o !== e) begin errors++; $display("FAIL overrun_event got edge %0d kind %0d want edge %0d kind %0d", o / 4 - t0, o % 4, e / 4 - t0, e % 4); end
        end
        checks++; if (obs_d.size() != 0) begin errors++; $display("FAIL overrun_extra got %0d events want 0", obs_d.size()); end
        checks++; if (if_d.ovr_cnt !== 8'd1) begin errors++; $display("FAIL overrun_ovr_cnt got %0d want 1", if_d.ovr_cnt); end
        checks++; if (if_d.match_cnt !== 8'd1) begin errors++; $display("FAIL overrun_match_cnt got %0d want 1", if_d.match_cnt); end
    endtask

    task automatic test_back_to_back();
        int t0, e, o;
        logic [31:0] bv;
        do_reset();
        t0 = edge_n;
        exp_d.push_back((t0 + 2) * 4 + 1);
        exp_d.push_back((t0 + 4) * 4 + 2);
        exp_d.push_back((t0 + 5) * 4 + 1);
        exp_d.push_back((t0 + 7) * 4 + 2);
        drive(0, 32'b1001, 9, bv);
        repeat (2) @(negedge clk);
        exp_d.sort();
        while (exp_d.size() > 0) begin
            e = exp_d.pop_front();
            o = (obs_d.size() > 0) ? obs_d.pop_front() : -4;
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_event got edge %0d kind %0d want edge %0d kind %0d", o / 4 - t0, o % 4, e / 4 - t0, e % 4); end
        end
        checks++; if (obs_d.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d events want 0", obs_d.size()); end
        checks++; if (if_d.ovr_cnt !== 8'd0) begin errors++; $display("FAIL b2b_ovr_cnt got %0d want 0", if_d.ovr_cnt); end
        checks++; if (if_d.match_cnt !== 8'd2) begin errors++; $display("FAIL b2b_match_cnt got %0d want 2", if_d.match_cnt); end
    endtask

    // ACK_DLY=3, TAIL=1: request at 1, dropped request at 3 (DLY), chained request at 5.
    task automatic test_slow_timing();
        int t0, e, o;
        logic [31:0] bv;
        do_reset();
        t0 = edge_n;
        exp_s.push_back((t0 + 4) * 4 + 1);
        exp_s.push_back((t0 + 4) * 4 + 3);
        exp_s.push_back((t0 + 5) * 4 + 2);
        exp_s.push_back((t0 + 8) * 4 + 1);
        exp_s.push_back((t0 + 9) * 4 + 2);
        drive(1, 32'b10101, 11, bv);
        repeat (2) @(negedge clk);
        exp_s.sort();
        while (exp_s.size() > 0) begin
            e = exp_s.pop_front();
            o = (obs_s.size() > 0) ? obs_s.pop_front() : -4;
            checks++;
            if (o !== e) begin errors++; $display("FAIL slow_event got edge %0d kind %0d want edge %0d kind %0d", o / 4 - t0, o % 4, e / 4 - t0, e % 4); end
        end
        checks++; if (obs_s.size() != 0) begin errors++; $display("FAIL slow_extra got %0d events want 0", obs_s.size()); end
        checks++; if (if_s.ovr_cnt !== 8'd1) begin errors++; $display("FAIL slow_ovr_cnt got %0d want 1", if_s.ovr_cnt); end
        checks++; if (if_s.match_cnt !== 8'd2) begin errors++; $display("FAIL slow_match_cnt got %0d want 2", if_s.match_cnt); end
    endtask

    task automatic test_reset_mid();
        int t0, e, o;
        logic [31:0] bv;
        do_reset();
        t0 = edge_n;
        exp_d.push_back((t0 + 2) * 4 + 1);
        drive(0, 32'h1, 2, bv);
        checks++; if (if_d.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", if_d.busy); end
        #1 rst = 1'b1;
        #1;
        checks++; if (if_d.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", if_d.busy); end
        checks++; if (if_d.b !== 1'b0) begin errors++; $display("FAIL rstmid_b got %b want 0", if_d.b); end
        checks++; if (if_d.match !== 1'b0) begin errors++; $display("FAIL rstmid_match got %b want 0", if_d.match); end
        checks++; if (if_d.ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", if_d.ready); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (if_d.match_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_match_cnt got %0d want 0", if_d.match_cnt); end
        t0 = edge_n;
        exp_d.push_back((t0 + 2) * 4 + 1);
        exp_d.push_back((t0 + 4) * 4 + 2);
        drive(0, 32'h1, 7, bv);
        exp_d.sort();
        while (exp_d.size() > 0) begin
            e = exp_d.pop_front();
            o = (obs_d.size() > 0) ? obs_d.pop_front() : -4;
            checks++;
            if (o !== e) begin errors++; $display("FAIL rstmid_event got code %0d want code %0d", o, e); end
        end
        checks++; if (obs_d.size() != 0) begin errors++; $display("FAIL rstmid_extra got %0d events want 0", obs_d.size()); end
        checks++; if (if_d.match_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_match_cnt_after got %0d want 1", if_d.match_cnt); end
    endtask

    task automatic test_saturation();
        logic [31:0] bv;
        do_reset();
        drive(2, 32'b1001, 8, bv);
        checks++; if (if_t.match_cnt !== 2'd2) begin errors++; $display("FAIL sat_two got %0d want 2", if_t.match_cnt); end
        drive(2, 32'b1001001, 12, bv);
        checks++; if (if_t.match_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d want 3", if_t.match_cnt); end
        checks++; if (if_t.ovr_cnt !== 2'd0) begin errors++; $display("FAIL sat_ovr_cnt got %0d want 0", if_t.ovr_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        if_d.a = 1'b0;
        if_s.a = 1'b0;
        if_t.a = 1'b0;
        test_reset();
        test_single();
        test_overrun();
        test_back_to_back();
        test_slow_timing();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
